alu_result_monitor: RTL and testbench
=====================================

Name: alu_result_monitor

Overview:
- Synthesizable response-side checker for the WIDTH-bit ALU. It watches the same A/B/ALUctr bus a stimulus driver applies, plus the ALU's Result/Zero/Overflow.
- Computes the golden response in a two-stage pipeline, counts checks and mismatches, and captures the first failing transaction.
- Sits beside the ALU in simulation benches and in on-chip self-test builds.

Parameters:
- WIDTH, 8, operand/result width in bits.
- CW, 16, width of the check and error counters.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- mon_valid  input  1  the A/B/ALUctr/Result/Zero/Overflow bus holds a settled transaction this cycle.
- clr  input  1  synchronous clear of counters, sticky flag and capture registers.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- ALUctr  input  3  operation code.
- Result  input  WIDTH  ALU result under test.
- Zero  input  1  ALU zero flag under test.
- Overflow  input  1  ALU overflow flag under test.
- check_count  output  CW  transactions compared, saturating.
- err_count  output  CW  mismatching transactions, saturating.
- mismatch  output  1  one-cycle pulse per failing transaction.
- err_flag  output  1  sticky; set on first mismatch.
- err_op  output  3  ALUctr of the first failing transaction.
- err_a  output  WIDTH  A of the first failing transaction.
- err_b  output  WIDTH  B of the first failing transaction.
- err_result  output  WIDTH  Result of the first failing transaction.

Behaviour:
- Reset (rst_n low, asynchronous): all outputs and internal pipeline registers go to 0.
- ALUctr encoding:
  - 000 ADDU
  - 001 ADD (signed overflow)
  - 010 OR
  - 011 AND
  - 100 SUBU
  - 101 SUB (signed overflow)
  - 110 SLTU (result 1 if A<B unsigned, else 0)
  - 111 SLT (signed compare)
- Arithmetic is modulo 2^WIDTH.
- Expected Zero = (expected result == 0).
- Expected Overflow:
  - ADD: operands have the same sign and the result sign differs.
  - SUB: operands have differing signs and the result sign differs from A.
  - All other ops: expected Overflow is 0, and an asserted Overflow is a mismatch.
- Stage 1, at the edge where mon_valid=1: register A, B, ALUctr, Result, Zero, Overflow and set v1.
- Stage 2, at the next edge when v1=1:
  - Compute the expected values and compare all three fields.
  - check_count increments.
  - On any field differing: err_count increments and mismatch=1 for exactly that cycle.
  - If err_flag was 0: set err_flag and load err_op/err_a/err_b/err_result.
- Latency: a sample taken at edge k is reflected in the outputs after edge k+1.
- Throughput: one transaction per cycle; back-to-back mon_valid is fully supported.
- Counters saturate at 2^CW-1 and never wrap. err_count saturates independently of check_count.
- Capture registers hold until clr or reset; later mismatches only bump err_count.
- clr=1: on that edge, zero the counters, err_flag, capture registers, mismatch and both pipeline valids. A mon_valid asserted in the same cycle is discarded. clr has priority over every update.
- Reset asserted mid-pipeline discards in-flight samples. The first check after deassertion needs a fresh mon_valid.
- The block never back-pressures; there is no ready signal.

Test Plan:
- Matching SLTU, WIDTH=8: A=0x32, B=0x35, ALUctr=110, Result=0x01, Zero=0, Overflow=0, mon_valid for one cycle -> check_count=1 two edges later, err_count=0, mismatch never high.
- Matching ADD overflow: A=0x7F, B=0x01, ALUctr=001, Result=0x80, Overflow=1 -> no mismatch. Repeat with Overflow=0 -> mismatch pulse, err_flag=1, err_op=001, err_a=0x7F, err_result=0x80.
- First-error capture: back-to-back bad transactions OR (A=0x0F, B=0xF0, Result=0x00) then AND (A=0xFF, B=0x0F, Result=0x00) -> err_count=2, capture holds the OR values, mismatch high two consecutive cycles.
- Saturation with CW=4: 20 matching ADDU transactions -> check_count stops at 15. 20 bad ones -> err_count stops at 15.
- clr collision: assert clr in the same cycle as a bad mon_valid -> all counters and flags 0 afterwards, no mismatch pulse.
- Async reset mid-flight: drop rst_n between the sample edge and the compare edge of a bad transaction -> outputs go to 0 immediately, no mismatch after release.

Source files
------------

// File: rtl/alu_result_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : alu_result_monitor
//  Purpose  : Response-side checker for a WIDTH-bit ALU. Samples the ALU
//             operand/opcode bus together with the ALU's Result/Zero/Overflow,
//             recomputes the golden response one cycle later and compares
//             all three fields. Keeps saturating check/error counters, a
//             one-cycle mismatch pulse, a sticky error flag and a capture of
//             the first failing transaction.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk         in   rising-edge clock
//    rst_n       in   asynchronous active-low reset
//    mon_valid   in   bus holds a settled transaction this cycle
//    clr         in   synchronous clear of counters, flag, capture, pipeline
//    A, B        in   operands (WIDTH)
//    ALUctr      in   operation code (3)
//    Result      in   ALU result under test (WIDTH)
//    Zero        in   ALU zero flag under test
//    Overflow    in   ALU overflow flag under test
//    check_count out  transactions compared, saturating (CW)
//    err_count   out  mismatching transactions, saturating (CW)
//    mismatch    out  one-cycle pulse per failing transaction
//    err_flag    out  sticky, set on first mismatch
//    err_op      out  ALUctr of first failing transaction
//    err_a/err_b out  operands of first failing transaction
//    err_result  out  Result of first failing transaction
// ============================================================================
module alu_result_monitor #(
  parameter int WIDTH = 8,
  parameter int CW    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mon_valid,
  input  logic             clr,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       ALUctr,
  input  logic [WIDTH-1:0] Result,
  input  logic             Zero,
  input  logic             Overflow,
  output logic [CW-1:0]    check_count,
  output logic [CW-1:0]    err_count,
  output logic             mismatch,
  output logic             err_flag,
  output logic [2:0]       err_op,
  output logic [WIDTH-1:0] err_a,
  output logic [WIDTH-1:0] err_b,
  output logic [WIDTH-1:0] err_result
);

  // --------------------------------------------------------------------------
  // Opcode encoding and counter constants
  // --------------------------------------------------------------------------
  localparam logic [2:0] OP_ADDU = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_OR   = 3'b010;
  localparam logic [2:0] OP_AND  = 3'b011;
  localparam logic [2:0] OP_SUBU = 3'b100;
  localparam logic [2:0] OP_SUB  = 3'b101;
  localparam logic [2:0] OP_SLTU = 3'b110;
  localparam logic [2:0] OP_SLT  = 3'b111;

  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  // --------------------------------------------------------------------------
  // Stage 1: sample register
  // --------------------------------------------------------------------------
  logic             v1_q;
  logic [WIDTH-1:0] a1_q;
  logic [WIDTH-1:0] b1_q;
  logic [2:0]       op1_q;
  logic [WIDTH-1:0] res1_q;
  logic             z1_q;
  logic             ov1_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q   <= 1'b0;
      a1_q   <= '0;
      b1_q   <= '0;
      op1_q  <= '0;
      res1_q <= '0;
      z1_q   <= 1'b0;
      ov1_q  <= 1'b0;
    end else if (clr) begin
      // A sample presented together with clr is discarded.
      v1_q   <= 1'b0;
    end else begin
      v1_q <= mon_valid;
      if (mon_valid) begin
        a1_q   <= A;
        b1_q   <= B;
        op1_q  <= ALUctr;
        res1_q <= Result;
        z1_q   <= Zero;
        ov1_q  <= Overflow;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stage 2: golden model (combinational on the stage-1 sample)
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] sum_w;
  logic [WIDTH-1:0] diff_w;
  logic             ltu_w;
  logic             lts_w;
  logic             add_ovf_w;
  logic             sub_ovf_w;
  logic [WIDTH-1:0] exp_result;
  logic             exp_zero;
  logic             exp_ovf;
  logic             fail_w;

  assign sum_w  = a1_q + b1_q;
  assign diff_w = a1_q - b1_q;
  assign ltu_w  = (a1_q < b1_q);
  assign lts_w  = ($signed(a1_q) < $signed(b1_q));

  // Signed overflow from sign bits: ADD overflows when both operands share a
  // sign that the sum does not; SUB overflows when the operand signs differ
  // and the difference takes the sign of B rather than A.
  assign add_ovf_w = (a1_q[WIDTH-1] == b1_q[WIDTH-1]) &&
                     (sum_w[WIDTH-1] != a1_q[WIDTH-1]);
  assign sub_ovf_w = (a1_q[WIDTH-1] != b1_q[WIDTH-1]) &&
                     (diff_w[WIDTH-1] != a1_q[WIDTH-1]);

  always_comb begin
    exp_result = '0;
    exp_ovf    = 1'b0;
    case (op1_q)
      OP_ADDU: exp_result = sum_w;
      OP_ADD: begin
        exp_result = sum_w;
        exp_ovf    = add_ovf_w;
      end
      OP_OR:   exp_result = a1_q | b1_q;
      OP_AND:  exp_result = a1_q & b1_q;
      OP_SUBU: exp_result = diff_w;
      OP_SUB: begin
        exp_result = diff_w;
        exp_ovf    = sub_ovf_w;
      end
      OP_SLTU: exp_result = {{(WIDTH-1){1'b0}}, ltu_w};
      OP_SLT:  exp_result = {{(WIDTH-1){1'b0}}, lts_w};
      default: exp_result = '0;
    endcase
  end

  assign exp_zero = (exp_result == '0);

  // Any of the three fields differing makes the transaction a failure;
  // an asserted Overflow on a non-overflowing op falls out of exp_ovf=0.
  assign fail_w = v1_q && ((res1_q != exp_result) ||
                           (z1_q   != exp_zero)   ||
                           (ov1_q  != exp_ovf));

  // --------------------------------------------------------------------------
  // Result / bookkeeping registers
  // --------------------------------------------------------------------------
  logic [CW-1:0]    check_count_q, check_count_d;
  logic [CW-1:0]    err_count_q,   err_count_d;
  logic             mismatch_q,    mismatch_d;
  logic             err_flag_q,    err_flag_d;
  logic [2:0]       err_op_q,      err_op_d;
  logic [WIDTH-1:0] err_a_q,       err_a_d;
  logic [WIDTH-1:0] err_b_q,       err_b_d;
  logic [WIDTH-1:0] err_result_q,  err_result_d;

  always_comb begin
    check_count_d = check_count_q;
    err_count_d   = err_count_q;
    mismatch_d    = 1'b0;
    err_flag_d    = err_flag_q;
    err_op_d      = err_op_q;
    err_a_d       = err_a_q;
    err_b_d       = err_b_q;
    err_result_d  = err_result_q;

    if (clr) begin
      // clr overrides any compare that would complete on this edge.
      check_count_d = '0;
      err_count_d   = '0;
      err_flag_d    = 1'b0;
      err_op_d      = '0;
      err_a_d       = '0;
      err_b_d       = '0;
      err_result_d  = '0;
    end else if (v1_q) begin
      if (check_count_q != CNT_MAX) begin
        check_count_d = check_count_q + CNT_ONE;
      end
      if (fail_w) begin
        mismatch_d = 1'b1;
        if (err_count_q != CNT_MAX) begin
          err_count_d = err_count_q + CNT_ONE;
        end
        // Only the first failure since reset/clr is captured.
        if (!err_flag_q) begin
          err_flag_d   = 1'b1;
          err_op_d     = op1_q;
          err_a_d      = a1_q;
          err_b_d      = b1_q;
          err_result_d = res1_q;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      check_count_q <= '0;
      err_count_q   <= '0;
      mismatch_q    <= 1'b0;
      err_flag_q    <= 1'b0;
      err_op_q      <= '0;
      err_a_q       <= '0;
      err_b_q       <= '0;
      err_result_q  <= '0;
    end else begin
      check_count_q <= check_count_d;
      err_count_q   <= err_count_d;
      mismatch_q    <= mismatch_d;
      err_flag_q    <= err_flag_d;
      err_op_q      <= err_op_d;
      err_a_q       <= err_a_d;
      err_b_q       <= err_b_d;
      err_result_q  <= err_result_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign check_count = check_count_q;
  assign err_count   = err_count_q;
  assign mismatch    = mismatch_q;
  assign err_flag    = err_flag_q;
  assign err_op      = err_op_q;
  assign err_a       = err_a_q;
  assign err_b       = err_b_q;
  assign err_result  = err_result_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_result_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_result_monitor
//  Purpose  : Self-checking bench for alu_result_monitor (WIDTH=8, CW=4).
//             Expected transactions are queued when driven and retired by a
//             negedge checker that keeps a reference model of the counters,
//             the sticky flag and the first-failure capture.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_result_monitor;

  localparam int WIDTH = 8;
  localparam int CW    = 4;
  localparam int CMAX  = (1 << CW) - 1;

  logic             clk;
  logic             rst_n;
  logic             mon_valid;
  logic             clr;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [2:0]       ALUctr;
  logic [WIDTH-1:0] Result;
  logic             Zero;
  logic             Overflow;
  logic [CW-1:0]    check_count;
  logic [CW-1:0]    err_count;
  logic             mismatch;
  logic             err_flag;
  logic [2:0]       err_op;
  logic [WIDTH-1:0] err_a;
  logic [WIDTH-1:0] err_b;
  logic [WIDTH-1:0] err_result;

  alu_result_monitor #(.WIDTH(WIDTH), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .mon_valid(mon_valid), .clr(clr),
    .A(A), .B(B), .ALUctr(ALUctr), .Result(Result), .Zero(Zero),
    .Overflow(Overflow), .check_count(check_count), .err_count(err_count),
    .mismatch(mismatch), .err_flag(err_flag), .err_op(err_op),
    .err_a(err_a), .err_b(err_b), .err_result(err_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------------------------------------------------------- checking
  int n_chk  = 0;
  int n_pass = 0;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  // ------------------------------------------------------------ golden model
  task automatic golden(input logic [7:0] a, input logic [7:0] b,
                        input logic [2:0] op, output logic [7:0] res,
                        output logic z, output logic ov);
    int sa, sb, s;
    sa = int'($signed(a));
    sb = int'($signed(b));
    ov = 1'b0;
    case (op)
      3'd0: res = a + b;
      3'd1: begin res = a + b; s = sa + sb; ov = (s > 127) || (s < -128); end
      3'd2: res = a | b;
      3'd3: res = a & b;
      3'd4: res = a - b;
      3'd5: begin res = a - b; s = sa - sb; ov = (s > 127) || (s < -128); end
      3'd6: res = (int'(a) < int'(b)) ? 8'd1 : 8'd0;
      default: res = (sa < sb) ? 8'd1 : 8'd0;
    endcase
    z = (res == 8'd0);
  endtask

  // -------------------------------------------------------------- scoreboard
  typedef struct {
    int         due;
    bit         bad;
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
  } exp_t;

  exp_t q[$];
  int   clr_due = -1;

  int         m_chk  = 0;
  int         m_err  = 0;
  bit         m_flag = 0;
  logic [2:0] m_op   = '0;
  logic [7:0] m_a    = '0;
  logic [7:0] m_b    = '0;
  logic [7:0] m_res  = '0;

  task automatic model_zero();
    q.delete();
    m_chk = 0; m_err = 0; m_flag = 0;
    m_op = '0; m_a = '0; m_b = '0; m_res = '0;
  endtask

  task automatic compare_all(input string pfx, input bit exp_mm);
    check_eq({pfx, "_mismatch"},    32'(mismatch),    32'(exp_mm));
    check_eq({pfx, "_check_count"}, 32'(check_count), 32'(m_chk));
    check_eq({pfx, "_err_count"},   32'(err_count),   32'(m_err));
    check_eq({pfx, "_err_flag"},    32'(err_flag),    32'(m_flag));
    check_eq({pfx, "_err_op"},      32'(err_op),      32'(m_op));
    check_eq({pfx, "_err_a"},       32'(err_a),       32'(m_a));
    check_eq({pfx, "_err_b"},       32'(err_b),       32'(m_b));
    check_eq({pfx, "_err_result"},  32'(err_result),  32'(m_res));
  endtask

  always @(negedge clk) begin
    bit   exp_mm;
    exp_t e;
    exp_mm = 1'b0;
    if (!rst_n) begin
      model_zero();
      clr_due = -1;
      compare_all("reset", 1'b0);
    end else begin
      if (cyc == clr_due) begin
        model_zero();
        clr_due = -1;
      end
      if (q.size() > 0 && q[0].due == cyc) begin
        e = q.pop_front();
        if (m_chk < CMAX) m_chk++;
        if (e.bad) begin
          exp_mm = 1'b1;
          if (m_err < CMAX) m_err++;
          if (!m_flag) begin
            m_flag = 1'b1;
            m_op = e.op; m_a = e.a; m_b = e.b; m_res = e.res;
          end
        end
      end
      compare_all("run", exp_mm);
    end
  end

  // ---------------------------------------------------------------- stimulus
  task automatic drive(input logic [7:0] a, input logic [7:0] b,
                       input logic [2:0] op, input logic [7:0] res,
                       input logic z, input logic ov);
    logic [7:0] gr;
    logic       gz, gov;
    exp_t       e;
    @(negedge clk);
    A = a; B = b; ALUctr = op; Result = res; Zero = z; Overflow = ov;
    mon_valid = 1'b1;
    clr       = 1'b0;
    golden(a, b, op, gr, gz, gov);
    e.due = cyc + 2;
    e.bad = (gr != res) || (gz != z) || (gov != ov);
    e.op = op; e.a = a; e.b = b; e.res = res;
    q.push_back(e);
  endtask

  task automatic drive_good(input logic [7:0] a, input logic [7:0] b,
                            input logic [2:0] op);
    logic [7:0] gr;
    logic       gz, gov;
    golden(a, b, op, gr, gz, gov);
    drive(a, b, op, gr, gz, gov);
  endtask

  // corrupt one field: 0 result, 1 zero flag, 2 overflow flag
  task automatic drive_bad(input logic [7:0] a, input logic [7:0] b,
                           input logic [2:0] op, input int kind);
    logic [7:0] gr;
    logic       gz, gov;
    golden(a, b, op, gr, gz, gov);
    case (kind)
      0:       drive(a, b, op, gr ^ 8'(($urandom_range(1, 255))), gz, gov);
      1:       drive(a, b, op, gr, ~gz, gov);
      default: drive(a, b, op, gr, gz, ~gov);
    endcase
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      mon_valid = 1'b0;
      clr       = 1'b0;
    end
  endtask

  // clr pulse, optionally colliding with a bad transaction on the bus
  task automatic pulse_clr(input bit with_bad);
    @(negedge clk);
    clr       = 1'b1;
    mon_valid = with_bad;
    if (with_bad) begin
      A = 8'h0F; B = 8'hF0; ALUctr = 3'b010; Result = 8'h00;
      Zero = 1'b1; Overflow = 1'b0;
    end
    clr_due = cyc + 1;
    @(negedge clk);
    clr       = 1'b0;
    mon_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; mon_valid = 1'b0; clr = 1'b0;
    A = '0; B = '0; ALUctr = '0; Result = '0; Zero = 1'b0; Overflow = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // Matching SLTU
    drive(8'h32, 8'h35, 3'b110, 8'h01, 1'b0, 1'b0);
    idle(3);

    // ADD with overflow, correct then with Overflow dropped
    drive(8'h7F, 8'h01, 3'b001, 8'h80, 1'b0, 1'b1);
    idle(2);
    drive(8'h7F, 8'h01, 3'b001, 8'h80, 1'b0, 1'b0);
    idle(3);

    // First-error capture: back-to-back bad OR then bad AND
    pulse_clr(1'b0);
    drive(8'h0F, 8'hF0, 3'b010, 8'h00, 1'b1, 1'b0);
    drive(8'hFF, 8'h0F, 3'b011, 8'h00, 1'b1, 1'b0);
    idle(3);
    check_eq("capture_err_count", 32'(err_count), 32'd2);
    check_eq("capture_err_op",    32'(err_op),    32'd2);
    check_eq("capture_err_a",     32'(err_a),     32'h0F);
    check_eq("capture_err_b",     32'(err_b),     32'hF0);

    // Spurious overflow on a logic op is a failure
    drive(8'h12, 8'h34, 3'b011, 8'h10, 1'b0, 1'b1);
    idle(3);

    // clr colliding with a bad sample; a bad compare is also in flight
    drive_bad(8'h10, 8'h20, 3'b000, 0);
    pulse_clr(1'b1);
    idle(3);
    check_eq("clr_collide_checks", 32'(check_count), 32'd0);
    check_eq("clr_collide_flag",   32'(err_flag),    32'd0);

    // Saturation: 20 good then 20 bad
    for (int i = 0; i < 20; i++)
      drive_good(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 3'b000);
    idle(3);
    check_eq("sat_check_count", 32'(check_count), 32'(CMAX));
    check_eq("sat_err_zero",    32'(err_count),   32'd0);
    pulse_clr(1'b0);
    for (int i = 0; i < 20; i++)
      drive_bad(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                3'($urandom_range(0, 7)), i % 3);
    idle(3);
    check_eq("sat_err_count", 32'(err_count), 32'(CMAX));

    // Random mix over all ops, including corner operands
    pulse_clr(1'b0);
    for (int i = 0; i < 80; i++) begin
      logic [7:0] ra, rb;
      ra = (i % 8 == 0) ? 8'h80 : (i % 8 == 1) ? 8'h7F : 8'($urandom_range(0, 255));
      rb = (i % 5 == 0) ? ra : 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0)
        drive_bad(ra, rb, 3'($urandom_range(0, 7)), int'($urandom_range(0, 2)));
      else
        drive_good(ra, rb, 3'($urandom_range(0, 7)));
      if (i % 10 == 9) pulse_clr(1'b0);
    end
    idle(3);

    // Async reset between sample and compare of a bad transaction
    drive_bad(8'h55, 8'hAA, 3'b101, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    mon_valid = 1'b0;
    #1;
    check_eq("async_rst_mismatch",    32'(mismatch),    32'd0);
    check_eq("async_rst_check_count", 32'(check_count), 32'd0);
    check_eq("async_rst_err_count",   32'(err_count),   32'd0);
    check_eq("async_rst_err_flag",    32'(err_flag),    32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(4);

    // First check after release needs a fresh sample
    drive_good(8'h80, 8'h01, 3'b101);
    idle(3);
    check_eq("post_rst_check_count", 32'(check_count), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
